// File: rtl/comparch_mem_arbiter_if.sv
// Bus bundle between the two memory masters, the arbiter and the shared 8K x 16 memory.
// Lock inputs lock0/lock1 exist only when ARB_LOCK_EN is defined.
interface comparch_mem_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              owner;

`ifdef ARB_LOCK_EN
    logic              lock0;
    logic              lock1;

    modport slave (
        input  req0, we0, addr0, wdata0, lock0,
        input  req1, we1, addr1, wdata1, lock1,
        output ack0, rdata0, ack1, rdata1,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output req0, we0, addr0, wdata0, lock0,
        output req1, we1, addr1, wdata1, lock1,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
`else
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, ack1, rdata1,
        output mem_rd, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, owner
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_rd, mem_wr, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, owner
    );
`endif
endinterface

// File: rtl/comparch_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-ported memory: one access at a time.
// Define ARB_LOCK_EN to add lock0/lock1, letting an owner keep the memory across accesses.
module comparch_mem_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input logic                   clk,
    input logic                   reset,
    comparch_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t            state, state_nx;
    logic [3:0]        lat_cnt;
    logic              last_owner;
    logic              owner_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              grant;
    logic              grant_port;
`ifdef ARB_LOCK_EN
    logic              lock_q;
    logic              lock_req;

    assign lock_req = last_owner ? bus.req1 : bus.req0;
`endif

    // A held lock overrides round-robin only while the locking owner keeps requesting.
    always_comb begin
        grant      = 1'b0;
        grant_port = 1'b0;
`ifdef ARB_LOCK_EN
        if (lock_q && lock_req) begin
            grant      = 1'b1;
            grant_port = last_owner;
        end else
`endif
        if (bus.req0 && bus.req1) begin
            grant      = 1'b1;
            grant_port = ~last_owner;
        end else if (bus.req0 || bus.req1) begin
            grant      = 1'b1;
            grant_port = bus.req1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant) state_nx = ACCESS;
            ACCESS:  if (lat_cnt == 4'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_cnt    <= 4'd0;
            last_owner <= 1'b1;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifdef ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef ARB_LOCK_EN
                    if (lock_q && !lock_req) lock_q <= 1'b0;
`endif
                    if (grant) begin
                        owner_q    <= grant_port;
                        last_owner <= grant_port;
                        we_q       <= grant_port ? bus.we1    : bus.we0;
                        addr_q     <= grant_port ? bus.addr1  : bus.addr0;
                        wdata_q    <= grant_port ? bus.wdata1 : bus.wdata0;
                        lat_cnt    <= LAT_LOAD;
                    end
                end
                ACCESS: begin
                    if (lat_cnt != 4'd0) begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end else if (!we_q) begin
                        // Read data is only valid on the final strobe cycle.
                        if (owner_q) rdata1_q <= bus.mem_rdata;
                        else         rdata0_q <= bus.mem_rdata;
                    end
                end
                RESP: begin
`ifdef ARB_LOCK_EN
                    lock_q <= owner_q ? bus.lock1 : bus.lock0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Strobes and acks decode straight from state so an async reset drops them at once.
    assign bus.mem_rd    = (state == ACCESS) && !we_q;
    assign bus.mem_wr    = (state == ACCESS) &&  we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack0      = (state == RESP) && !owner_q;
    assign bus.ack1      = (state == RESP) &&  owner_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state != IDLE);
    assign bus.owner     = owner_q;
endmodule

// File: tb/tb_comparch_mem_arbiter.sv
// Directed bench for comparch_mem_arbiter: three instances with MEM_LAT 1, 4 and 3.
// Inputs change and outputs are sampled at the falling clock edge.
module tb_comparch_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    comparch_mem_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus1 ();
    comparch_mem_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus4 ();
    comparch_mem_arbiter_if #(.ADDR_W(13), .DATA_W(16)) bus3 ();

    comparch_mem_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    comparch_mem_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LAT(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4));
    comparch_mem_arbiter #(.ADDR_W(13), .DATA_W(16), .MEM_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic nclk;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ack_cnt;
        int last_t;
        int exp_port [4] = '{0, 1, 0, 1};
        int first_port;
        int first_t;
        int second_t;
        logic any_ack;

        reset = 1'b1;
        bus1.req0 = 0; bus1.we0 = 0; bus1.addr0 = '0; bus1.wdata0 = '0;
        bus1.req1 = 0; bus1.we1 = 0; bus1.addr1 = '0; bus1.wdata1 = '0; bus1.mem_rdata = '0;
        bus4.req0 = 0; bus4.we0 = 0; bus4.addr0 = '0; bus4.wdata0 = '0;
        bus4.req1 = 0; bus4.we1 = 0; bus4.addr1 = '0; bus4.wdata1 = '0; bus4.mem_rdata = '0;
        bus3.req0 = 0; bus3.we0 = 0; bus3.addr0 = '0; bus3.wdata0 = '0;
        bus3.req1 = 0; bus3.we1 = 0; bus3.addr1 = '0; bus3.wdata1 = '0; bus3.mem_rdata = '0;
`ifdef ARB_LOCK_EN
        bus1.lock0 = 0; bus1.lock1 = 0; bus4.lock0 = 0; bus4.lock1 = 0;
        bus3.lock0 = 0; bus3.lock1 = 0;
`endif
        nclk;
        chk("rst_ack0", bus1.ack0, 0);
        chk("rst_ack1", bus1.ack1, 0);
        chk("rst_mem_rd", bus1.mem_rd, 0);
        chk("rst_mem_wr", bus1.mem_wr, 0);
        chk("rst_busy", bus1.busy, 0);
        chk("rst_owner", bus1.owner, 0);
        chk("rst_mem_addr", bus1.mem_addr, 0);
        chk("rst_rdata0", bus1.rdata0, 0);
        nclk;
        reset = 1'b0;
        nclk;

        // Single read, MEM_LAT=1
        bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 13'h0005; bus1.mem_rdata = 16'h2A07;
        nclk;
        chk("rd1_mem_rd", bus1.mem_rd, 1);
        chk("rd1_mem_wr", bus1.mem_wr, 0);
        chk("rd1_mem_addr", bus1.mem_addr, 13'h0005);
        chk("rd1_busy", bus1.busy, 1);
        chk("rd1_early_ack", bus1.ack0, 0);
        bus1.req0 = 0;
        nclk;
        chk("rd1_ack0", bus1.ack0, 1);
        chk("rd1_ack1", bus1.ack1, 0);
        chk("rd1_strobe_off", bus1.mem_rd, 0);
        chk("rd1_rdata0", bus1.rdata0, 16'h2A07);
        chk("rd1_owner", bus1.owner, 0);
        nclk;
        chk("rd1_busy_end", bus1.busy, 0);
        chk("rd1_ack_end", bus1.ack0, 0);

        // Port 1 write at top address with all-ones data
        bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 13'h1FFF; bus1.wdata1 = 16'hFFFF;
        bus1.mem_rdata = 16'h1234;
        nclk;
        chk("wr_mem_wr", bus1.mem_wr, 1);
        chk("wr_mem_rd", bus1.mem_rd, 0);
        chk("wr_mem_addr", bus1.mem_addr, 13'h1FFF);
        chk("wr_mem_wdata", bus1.mem_wdata, 16'hFFFF);
        chk("wr_owner", bus1.owner, 1);
        bus1.req1 = 0; bus1.we1 = 0;
        nclk;
        chk("wr_ack1", bus1.ack1, 1);
        chk("wr_ack0", bus1.ack0, 0);
        chk("wr_strobe_off", bus1.mem_wr, 0);
        chk("wr_rdata1", bus1.rdata1, 0);
        chk("wr_rdata0_kept", bus1.rdata0, 16'h2A07);
        nclk;
        chk("wr_busy_end", bus1.busy, 0);
        chk("wr_addr_hold", bus1.mem_addr, 13'h1FFF);

        // Contention: both ports hold reads continuously
        bus1.req0 = 1; bus1.req1 = 1; bus1.addr0 = 13'h0010; bus1.addr1 = 13'h0020;
        bus1.mem_rdata = 16'h0BEE;
        ack_cnt = 0;
        last_t = -1;
        for (int t = 1; t <= 12; t++) begin
            nclk;
            if (bus1.ack0 || bus1.ack1) begin
                if (ack_cnt < 4) chk("cont_port", {31'd0, bus1.ack1}, exp_port[ack_cnt]);
                chk("cont_both", {31'd0, bus1.ack0 & bus1.ack1}, 0);
                if (last_t >= 0) chk("cont_space", t - last_t, 3);
                last_t = t;
                ack_cnt++;
            end
            if (t == 11) begin bus1.req0 = 0; bus1.req1 = 0; end
        end
        chk("cont_acks", ack_cnt, 4);
        chk("cont_idle", bus1.busy, 0);
        chk("cont_rdata1", bus1.rdata1, 16'h0BEE);

`ifdef ARB_LOCK_EN
        // Lock: port 0 keeps the memory for one extra access
        bus1.req0 = 1; bus1.req1 = 1; bus1.lock0 = 1;
        ack_cnt = 0;
        for (int t = 1; t <= 15 && ack_cnt < 3; t++) begin
            nclk;
            if (bus1.ack0 || bus1.ack1) begin
                chk("lock_order", {31'd0, bus1.ack1}, (ack_cnt == 2) ? 1 : 0);
                ack_cnt++;
            end else if (ack_cnt >= 1) begin
                bus1.lock0 = 0;
            end
        end
        chk("lock_acks", ack_cnt, 3);
        bus1.req0 = 0; bus1.req1 = 0;
        nclk;
        nclk;
`endif

        // MEM_LAT=4 read: rdata must come from the last strobe cycle only
        bus4.req0 = 1; bus4.we0 = 0; bus4.addr0 = 13'h0ABC; bus4.mem_rdata = 16'h4000;
        for (int k = 1; k <= 4; k++) begin
            nclk;
            chk("lat4_mem_rd", bus4.mem_rd, 1);
            chk("lat4_no_ack", bus4.ack0, 0);
            if (k == 1) bus4.req0 = 0;
            bus4.mem_rdata = 16'h4000 + 16'(k);
        end
        nclk;
        chk("lat4_ack0", bus4.ack0, 1);
        chk("lat4_rd_off", bus4.mem_rd, 0);
        chk("lat4_rdata0", bus4.rdata0, 16'h4004);
        chk("lat4_mem_addr", bus4.mem_addr, 13'h0ABC);
        nclk;
        chk("lat4_busy_end", bus4.busy, 0);

        // MEM_LAT=3: reset in the second access cycle of a port 0 read
        bus3.req0 = 1; bus3.we0 = 0; bus3.addr0 = 13'h0033; bus3.mem_rdata = 16'h7777;
        nclk;
        chk("rst3_mem_rd_c1", bus3.mem_rd, 1);
        bus3.req0 = 0;
        nclk;
        chk("rst3_mem_rd_c2", bus3.mem_rd, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst3_async_rd", bus3.mem_rd, 0);
        chk("rst3_async_busy", bus3.busy, 0);
        chk("rst3_async_ack", bus3.ack0, 0);
        nclk;
        reset = 1'b0;
        any_ack = 1'b0;
        for (int t = 0; t < 4; t++) begin
            nclk;
            any_ack = any_ack | bus3.ack0 | bus3.ack1 | bus3.busy;
        end
        chk("rst3_lost", any_ack, 0);

        bus3.req0 = 1; bus3.req1 = 1; bus3.we0 = 0; bus3.we1 = 0;
        bus3.addr0 = 13'h0044; bus3.addr1 = 13'h0055; bus3.mem_rdata = 16'h5A5A;
        first_port = -1; first_t = -1; second_t = -1;
        for (int t = 1; t <= 20 && second_t < 0; t++) begin
            nclk;
            if (first_t < 0 && (bus3.ack0 || bus3.ack1)) begin
                first_port = bus3.ack1 ? 1 : 0;
                first_t = t;
                if (bus3.ack1) bus3.req1 = 0; else bus3.req0 = 0;
            end else if (first_t >= 0 && (bus3.ack0 || bus3.ack1)) begin
                second_t = t;
                chk("post_rst_rdata1", bus3.rdata1, 16'h5A5A);
                bus3.req0 = 0; bus3.req1 = 0;
            end
        end
        chk("post_rst_first_port", first_port, 0);
        chk("post_rst_first_t", first_t, 4);
        chk("post_rst_second_t", second_t, 9);
        chk("post_rst_rdata0", bus3.rdata0, 16'h5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/comparch_mem_arbiter.md
Name: comparch_mem_arbiter

Overview:
- Two-port arbiter/sequencer for the shared 8K x 16 CPU memory.
- Lets the CPU (port 0) and a second master, such as a loader or I/O engine (port 1), share one single-ported memory.
- Runs one memory access at a time: latches the winning request, drives the memory strobes for a fixed latency, then returns a one-cycle ack with read data.
- Sits between the masters and the memory model/RAM.

Parameters:
- ADDR_W, 13: word address width (8192 words).
- DATA_W, 16: data width.
- MEM_LAT, 1: cycles that mem_rd/mem_wr stay asserted per access. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 request. Held with we0/addr0/wdata0 stable until ack0.
- we0  in  1  port 0 operation: 1 = write, 0 = read.
- addr0  in  ADDR_W  port 0 word address.
- wdata0  in  DATA_W  port 0 write data.
- ack0  out  1  port 0 access complete, one-cycle pulse.
- rdata0  out  DATA_W  port 0 read data. Valid from ack0 onward.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data. Sampled on the last strobe cycle.
- busy  out  1  high when state is not IDLE.
- owner  out  1  port of the current or most recent access.

Behaviour:
- Reset values: all outputs 0, state IDLE, lat_cnt 0, last_owner = 1 (so port 0 wins the first tie).
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_owner (round-robin).
  - On grant: latch we/addr/wdata into mem_addr/mem_wdata, set owner and last_owner, load lat_cnt = MEM_LAT-1, go to ACCESS.
- ACCESS:
  - mem_rd = ~we_latched and mem_wr = we_latched, asserted for exactly MEM_LAT consecutive cycles.
  - mem_addr and mem_wdata are stable throughout.
  - lat_cnt decrements each cycle. When lat_cnt == 0: on a read, capture mem_rdata into rdata[owner]; go to RESP.
- RESP:
  - Strobes low; ack[owner] = 1 for exactly this cycle; go to IDLE.
- Latency: req sampled in IDLE at edge N → strobes in cycles N+1..N+MEM_LAT → ack in cycle N+MEM_LAT+1.
- Throughput: at most one access per MEM_LAT+2 cycles.
- A request dropped before its grant is ignored. A request dropped after its grant still completes and still acks (no abort).
- A request still high after its ack is re-arbitrated in the following IDLE cycle. The other port wins if it is also requesting.
- rdataN holds its value until the next read completion on that port. Writes never change rdataN.
- mem_addr and mem_wdata hold their last latched values while idle. mem_rd and mem_wr are never both high.
- Reset mid-access: strobes and ack fall immediately (asynchronous), state goes to IDLE, and the in-flight transaction is lost with no ack.
- Only the request inputs are sampled by the FSM. Operand inputs are sampled only at grant.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - If the owner's lock is high in its RESP cycle, the next IDLE grants only that owner, provided its req is high. The other port waits.
  - The lock releases when the owner's access completes with lock low, or when the owner's req is low in IDLE.
  - Intended for atomic read-modify-write sequences.
- Undefined: no lock ports; pure round-robin.

Test Plan:
- Single read, MEM_LAT=1: port 0 reads addr 0x0005, memory returns 0x2A07 → mem_rd high exactly in cycle N+1 with mem_addr 0x0005; ack0 in N+2; rdata0 = 0x2A07; owner = 0; busy low in N+3.
- Contention after reset: req0 and req1 held high continuously → grants alternate 0,1,0,1. ack pulses are one cycle each and spaced MEM_LAT+2 cycles apart.
- Port 1 write to addr 0x1FFF, data 0xFFFF → mem_wr high for MEM_LAT cycles; mem_addr 0x1FFF; mem_wdata 0xFFFF; ack1 pulses; rdata1 unchanged; mem_rd stays 0.
- MEM_LAT=4, read from port 0 → mem_rd high exactly 4 cycles (N+1..N+4); ack0 in N+5; mem_rdata is sampled only in cycle N+4.
- Reset pulse in the 2nd ACCESS cycle, MEM_LAT=3 → mem_rd and busy drop without waiting for a clock edge; no ack. A req1 read after reset release completes normally, and port 0 has tie priority again.
- ARB_LOCK_EN: port 0 requests with lock0 = 1 on its first access, lock0 = 0 on its second; req1 is high throughout → service order 0, 0, 1.
